// File: rtl/uc_pkg.sv
// -----------------------------------------------------------------------------
// uc_pkg -- shared definitions for the microcontroller sequencing control unit.
//
// Purpose : opcode constants, FSM state encoding, ALU operation encodings and
//           the decoded-strobe bundle exchanged between uc_decode and uc_seq.
// Ports   : none (package).
// Config  : UC_STEP_EN (used by uc_seq) enables single-step sequencing. The
//           ST_STEPW state is always declared here but is reachable only when
//           that macro is defined.
// -----------------------------------------------------------------------------
package uc_pkg;

  // Opcode[5] set selects the ALU class; Opcode[4:2] is then the ALU op.
  localparam int OPC_ALU_BIT = 5;

  // LI is a 4-bit prefix: matched against Opcode[5:2], low two bits are free.
  localparam logic [3:0] OPC_LI   = 4'b0000;
  localparam logic [5:0] OPC_J    = 6'b000100;
  localparam logic [5:0] OPC_JZ   = 6'b000101;
  localparam logic [5:0] OPC_JNZ  = 6'b000110;
  localparam logic [5:0] OPC_HALT = 6'b000111;

  // ALU operation encodings, as carried in Opcode[4:2] and driven on Op.
  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_NOT_A  = 3'b001;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_NEG_A  = 3'b110;
  localparam logic [2:0] ALU_NEG_B  = 3'b111;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10,
    ST_STEPW = 2'b11
  } uc_state_t;

  // Raw decode result, before gating by the sequencer state.
  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op;
    logic       halt;
  } uc_strobes_t;

  // Strobe values whenever nothing is executing: PC+1 select, no writes.
  localparam uc_strobes_t STROBES_IDLE = '{
    s_inc: 1'b1,
    s_inm: 1'b0,
    we3:   1'b0,
    wez:   1'b0,
    op:    ALU_PASS_A,
    halt:  1'b0
  };

endpackage

// File: rtl/uc_decode.sv
// -----------------------------------------------------------------------------
// uc_decode -- purely combinational instruction decoder.
//
// Purpose : map the 6-bit opcode and the registered zero flag onto the raw
//           datapath strobes. No state; uc_seq gates the result by FSM state.
// Ports   :
//   Opcode  in  6   Instruccion[15:10] from the datapath
//   z       in  1   registered zero flag
//   dec     out     uc_strobes_t bundle (s_inc, s_inm, we3, wez, op, halt)
// Config  : independent of UC_STEP_EN.
// -----------------------------------------------------------------------------
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0]  Opcode,
  input  logic        z,
  output uc_strobes_t dec
);

  always_comb begin
    dec = STROBES_IDLE;
    if (Opcode[OPC_ALU_BIT]) begin
      dec.op  = Opcode[4:2];
      dec.we3 = 1'b1;
      dec.wez = 1'b1;
    end else if (Opcode[5:2] == OPC_LI) begin
      dec.s_inm = 1'b1;
      dec.we3   = 1'b1;
    end else begin
      case (Opcode)
        OPC_J:    dec.s_inc = 1'b0;
        // Conditional jumps: s_inc=0 selects the jump target.
        OPC_JZ:   dec.s_inc = ~z;
        OPC_JNZ:  dec.s_inc = z;
        OPC_HALT: dec.halt  = 1'b1;
        default:  dec       = STROBES_IDLE;  // NOP
      endcase
    end
  end

endmodule

// File: rtl/uc_seq.sv
// -----------------------------------------------------------------------------
// uc_seq -- sequencing control unit for the 10-bit-PC / 16-bit-instruction
//           microcontroller datapath.
//
// Purpose : run/halt FSM (BOOT, EXEC, HALT, and STEPW when single-step is
//           built in), decoded-strobe gating, PC hold enable and a wrapping
//           retired-instruction counter.
// Ports   :
//   clk       in  1      system clock, rising edge
//   reset     in  1      asynchronous, active-low reset
//   Opcode    in  6      Instruccion[15:10]
//   z         in  1      registered zero flag
//   start     in  1      level; leaves HALT
//   step_req  in  1      single-step request       (UC_STEP_EN only)
//   s_inc     out 1      1: PC+1, 0: load Dir_salto
//   s_inm     out 1      1: write immediate, 0: write ALU result
//   we3       out 1      register-file write enable
//   wez       out 1      zero-flag write enable
//   Op        out 3      ALU operation
//   pc_en     out 1      PC load enable
//   halted    out 1      high in HALT
//   step_ack  out 1      one-cycle pulse per step   (UC_STEP_EN only)
//   icount    out CNT_W  retired-instruction count (wraps)
// Config  : define UC_STEP_EN to add step_req/step_ack and the STEPW state.
// -----------------------------------------------------------------------------
module uc_seq
  import uc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic             start,
`ifdef UC_STEP_EN
  input  logic             step_req,
  output logic             step_ack,
`endif
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] icount
);

  uc_strobes_t      dec;
  uc_state_t        state_q, state_d;
  logic [CNT_W-1:0] icount_q, icount_d;
`ifdef UC_STEP_EN
  // Marks an EXEC cycle that was entered by a step request, so the following
  // cycle goes to STEPW instead of continuing to run.
  logic             stepping_q, stepping_d;
`endif

  uc_decode u_decode (
    .Opcode (Opcode),
    .z      (z),
    .dec    (dec)
  );

  always_comb begin
    s_inc    = STROBES_IDLE.s_inc;
    s_inm    = STROBES_IDLE.s_inm;
    we3      = STROBES_IDLE.we3;
    wez      = STROBES_IDLE.wez;
    Op       = STROBES_IDLE.op;
    pc_en    = 1'b0;
    halted   = 1'b0;
    state_d  = state_q;
    icount_d = icount_q;
`ifdef UC_STEP_EN
    step_ack   = 1'b0;
    stepping_d = stepping_q;
`endif

    case (state_q)
      // Gives the synchronous program memory one cycle to present address 0.
      ST_BOOT: state_d = ST_EXEC;

      ST_EXEC: begin
        s_inc    = dec.s_inc;
        s_inm    = dec.s_inm;
        we3      = dec.we3;
        wez      = dec.wez;
        Op       = dec.op;
        pc_en    = ~dec.halt;
        // Every EXEC cycle retires one instruction, HALT included.
        icount_d = icount_q + CNT_W'(1);
        if (dec.halt) begin
          state_d = ST_HALT;
`ifdef UC_STEP_EN
          // A stepped HALT goes straight back to HALT without an ack.
          stepping_d = 1'b0;
        end else if (stepping_q) begin
          state_d    = ST_STEPW;
          stepping_d = 1'b0;
`endif
        end
      end

      ST_HALT: begin
        halted = 1'b1;
        if (start) begin
          state_d = ST_EXEC;
`ifdef UC_STEP_EN
          // start has priority over a simultaneous step request.
          stepping_d = 1'b0;
        end else if (step_req) begin
          state_d    = ST_EXEC;
          stepping_d = 1'b1;
`endif
        end
      end

`ifdef UC_STEP_EN
      ST_STEPW: begin
        step_ack = 1'b1;
        state_d  = ST_HALT;
      end
`endif

      default: state_d = ST_BOOT;
    endcase
  end

  // Outputs are combinational from state_q, so the asynchronous reset drops
  // every write enable in the same cycle it is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      icount_q   <= '0;
`ifdef UC_STEP_EN
      stepping_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      icount_q   <= icount_d;
`ifdef UC_STEP_EN
      stepping_q <= stepping_d;
`endif
    end
  end

  assign icount = icount_q;

endmodule

// File: tb/tb_uc_seq.sv
// -----------------------------------------------------------------------------
// tb_uc_seq -- directed self-checking bench for uc_seq (CNT_W=4 so that the
// counter wrap is reachable quickly). Step tests are built when UC_STEP_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_uc_seq;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       Opcode;
  logic             z;
  logic             start;
  logic             step_req;
  logic             step_ack;
  logic             s_inc, s_inm, we3, wez, pc_en, halted;
  logic [2:0]       Op;
  logic [CNT_W-1:0] icount;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  localparam logic [5:0] NOP = 6'b010110;

  always #5 clk = ~clk;

  uc_seq #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .Opcode   (Opcode),
    .z        (z),
    .start    (start),
`ifdef UC_STEP_EN
    .step_req (step_req),
    .step_ack (step_ack),
`endif
    .s_inc    (s_inc),
    .s_inm    (s_inm),
    .we3      (we3),
    .wez      (wez),
    .Op       (Op),
    .pc_en    (pc_en),
    .halted   (halted),
    .icount   (icount)
  );

`ifndef UC_STEP_EN
  assign step_ack = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One EXEC cycle: drive opcode/z after the edge, check strobes mid-cycle.
  task automatic exec_vec(input string tag, input logic [5:0] opc, input logic zv,
                          input logic e_sinc, input logic e_sinm, input logic e_we3,
                          input logic e_wez, input logic [2:0] e_op, input logic e_pcen);
    @(posedge clk); #1;
    Opcode = opc;
    z      = zv;
    @(negedge clk);
    check_eq({tag, ".s_inc"},  s_inc,  e_sinc);
    check_eq({tag, ".s_inm"},  s_inm,  e_sinm);
    check_eq({tag, ".we3"},    we3,    e_we3);
    check_eq({tag, ".wez"},    wez,    e_wez);
    check_eq({tag, ".Op"},     Op,     e_op);
    check_eq({tag, ".pc_en"},  pc_en,  e_pcen);
    check_eq({tag, ".halted"}, halted, 1'b0);
    check_eq({tag, ".icount"}, icount, exp_cnt % 16);
    exp_cnt++;
    $display("exec %-8s op=%b z=%b s_inc=%b s_inm=%b we3=%b wez=%b Op=%b pc_en=%b icount=%0d",
             tag, opc, zv, s_inc, s_inm, we3, wez, Op, pc_en, icount);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    Opcode   = NOP;
    z        = 1'b0;
    start    = 1'b0;
    step_req = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst.pc_en",  pc_en,  1'b0);
    check_eq("rst.s_inc",  s_inc,  1'b1);
    check_eq("rst.s_inm",  s_inm,  1'b0);
    check_eq("rst.we3",    we3,    1'b0);
    check_eq("rst.wez",    wez,    1'b0);
    check_eq("rst.Op",     Op,     3'b000);
    check_eq("rst.halted", halted, 1'b0);
    check_eq("rst.ack",    step_ack, 1'b0);
    check_eq("rst.icount", icount, 0);
    $display("reset  pc_en=%b halted=%b icount=%0d", pc_en, halted, icount);

    // Release just after an edge: exactly one BOOT cycle follows.
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("boot.pc_en", pc_en, 1'b0);
    check_eq("boot.we3",   we3,   1'b0);
    $display("boot   pc_en=%b", pc_en);

    //        tag       opcode     z     s_inc s_inm we3  wez  Op      pc_en
    exec_vec("alu_add", 6'b101000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 1'b1);
    exec_vec("li",      6'b000011, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    exec_vec("jz_z1",   6'b000101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    exec_vec("jz_z0",   6'b000101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    exec_vec("jnz_z1",  6'b000110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    exec_vec("jnz_z0",  6'b000110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    exec_vec("j",       6'b000100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    exec_vec("nop",     NOP,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    exec_vec("alu_7",   6'b111100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b111, 1'b1);
    exec_vec("halt",    6'b000111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

    // HALT state: counter frozen, no writes even with a writing opcode present.
    @(posedge clk); #1;
    Opcode = 6'b101000;
    @(negedge clk);
    check_eq("hlt.halted", halted, 1'b1);
    check_eq("hlt.pc_en",  pc_en,  1'b0);
    check_eq("hlt.we3",    we3,    1'b0);
    check_eq("hlt.wez",    wez,    1'b0);
    check_eq("hlt.icount", icount, exp_cnt % 16);
    $display("halt   halted=%b icount=%0d", halted, icount);
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    check_eq("hlt2.halted", halted, 1'b1);
    check_eq("hlt2.icount", icount, exp_cnt % 16);
    @(posedge clk); #1;
    start  = 1'b0;
    Opcode = NOP;
    @(negedge clk);
    check_eq("resume.halted", halted, 1'b0);
    check_eq("resume.pc_en",  pc_en,  1'b1);
    check_eq("resume.icount", icount, exp_cnt % 16);
    exp_cnt++;
    $display("resume pc_en=%b icount=%0d", pc_en, icount);

    // start held high through a HALT opcode still gives one HALT cycle.
    start = 1'b1;
    exec_vec("halt_st", 6'b000111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    @(posedge clk); #1;
    Opcode = NOP;
    @(negedge clk);
    check_eq("hst.halted", halted, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("hst.resume", pc_en, 1'b1);
    exp_cnt++;
    $display("start-held halt then resume pc_en=%b", pc_en);

`ifdef UC_STEP_EN
    exec_vec("halt_s",  6'b000111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    @(posedge clk); #1;
    Opcode   = NOP;
    step_req = 1'b1;
    @(negedge clk);
    check_eq("stp.halted", halted, 1'b1);
    @(posedge clk); #1;
    step_req = 1'b0;
    @(negedge clk);
    check_eq("stp.exec_pc",  pc_en,    1'b1);
    check_eq("stp.exec_ack", step_ack, 1'b0);
    exp_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("stp.ack",     step_ack, 1'b1);
    check_eq("stp.w_pc",    pc_en,    1'b0);
    check_eq("stp.w_icnt",  icount,   exp_cnt % 16);
    @(posedge clk); #1;
    start    = 1'b1;
    step_req = 1'b1;
    @(negedge clk);
    check_eq("stp.back",    halted,   1'b1);
    check_eq("stp.ack_off", step_ack, 1'b0);
    $display("step   one exec, ack, back to halt");
    @(posedge clk); #1;
    start    = 1'b0;
    step_req = 1'b0;
    @(negedge clk);
    check_eq("both.pc_en", pc_en, 1'b1);
    exp_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("both.run",  pc_en,    1'b1);
    check_eq("both.ack",  step_ack, 1'b0);
    exp_cnt++;
    $display("start+step runs without ack");
`endif

    // Reset mid-instruction: write enables drop in the same cycle.
    @(posedge clk); #1;
    Opcode = 6'b101000;
    #2;
    check_eq("mid.we3_pre", we3, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("mid.we3",    we3,    1'b0);
    check_eq("mid.wez",    wez,    1'b0);
    check_eq("mid.pc_en",  pc_en,  1'b0);
    check_eq("mid.Op",     Op,     3'b000);
    check_eq("mid.icount", icount, 0);
    $display("midrst we3=%b pc_en=%b icount=%0d", we3, pc_en, icount);
    @(posedge clk); #1;
    reset  = 1'b1;
    Opcode = NOP;
    @(negedge clk);
    check_eq("boot2.pc_en", pc_en, 1'b0);
    exp_cnt = 0;

    // 17 instructions on a 4-bit counter wrap to 1.
    for (int i = 0; i < 17; i++)
      exec_vec("wrap", NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    @(posedge clk); #1;
    check_eq("wrap.final", icount, 1);
    $display("wrap   icount=%0d after 17 instructions", icount);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uc_seq.md
# uc_seq

Sequencing control unit for the 10-bit-PC, 16-bit-instruction microcontroller datapath. Decodes the 6-bit `Opcode` and the registered `z` flag into the datapath strobes (`s_inc`, `s_inm`, `we3`, `wez`, `Op`). Adds run/halt sequencing, a PC hold enable and a retired-instruction counter. Sits beside the datapath at the microcontroller top level, one instance per core.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Opcode`  in  6  `Instruccion[15:10]` from the datapath.
- `z`  in  1  registered zero flag from the datapath.
- `start`  in  1  level; leaves HALT and resumes execution.
- `step_req`  in  1  single-step request; exists only with `UC_STEP_EN`.
- `s_inc`  out  1  1: PC+1; 0: load `Dir_salto`.
- `s_inm`  out  1  1: write immediate; 0: write ALU result.
- `we3`  out  1  register-file write enable.
- `wez`  out  1  zero-flag write enable.
- `Op`  out  3  ALU operation.
- `pc_en`  out  1  PC register load enable in the datapath.
- `halted`  out  1  high in HALT state.
- `step_ack`  out  1  one-cycle pulse per stepped instruction; exists only with `UC_STEP_EN`.
- `icount`  out  CNT_W  retired-instruction count.

## Operation
Decode is combinational and applies in EXEC only:
- `1xxxxx` ALU: `Op=Opcode[4:2]`, `we3=1`, `wez=1`, `s_inm=0`, `s_inc=1`.
- `0000xx` LI: `s_inm=1`, `we3=1`, `wez=0`, `s_inc=1`.
- `000100` J: `s_inc=0`.
- `000101` JZ: `s_inc=~z`.
- `000110` JNZ: `s_inc=z`.
- `000111` HALT: `s_inc=1`, `pc_en=0`, next state HALT.
- Any other opcode is a NOP: `s_inc=1`, no writes.

FSM states are BOOT, EXEC, HALT, and STEPW (STEPW only with the macro):
- BOOT: one cycle after reset release, so the synchronous program memory can present the instruction at address 0. `pc_en=0`, no writes. Next state is EXEC.
- EXEC: `pc_en=1`, decoded strobes are active, `icount` increments by 1 per cycle. HALT opcode moves to HALT and still counts as retired.
- HALT: `pc_en=0`, `we3=wez=0`, `halted=1`. `start=1` moves to EXEC; the PC already points past the HALT instruction.
- Outside EXEC, `we3`, `wez` and `s_inm` are 0, `Op=000`, and `s_inc=1`.
- `icount` wraps modulo 2^CNT_W without saturation.

## Timing
- Reset values: state=BOOT, `pc_en=0`, `s_inc=1`, `s_inm=0`, `we3=0`, `wez=0`, `Op=000`, `halted=0`, `step_ack=0`, `icount=0`.
- Reset asserted mid-instruction forces BOOT immediately. No write enable may remain high while `reset=0`.
- Strobes are combinational from state, `Opcode` and `z`. One instruction retires per EXEC cycle; a JZ/JNZ sees `z` as updated by the previous instruction.
- HALT exit: `start` sampled at edge N gives EXEC with `pc_en=1` in cycle N+1.
- `start` held high through a HALT opcode still enters HALT for at least one cycle.

## Configuration
`UC_STEP_EN`:
- Defined:
  - `step_req` and `step_ack` exist.
  - In HALT, `step_req=1` gives one EXEC cycle, then STEPW.
  - STEPW drives `step_ack=1` for one cycle and returns to HALT.
  - If both `start` and `step_req` are high, `start` wins.
  - A stepped HALT opcode returns to HALT with no ack.
- Undefined: ports and STEPW are absent; HALT exits only via `start`.

## Structure
- Shared package `uc_pkg`:
  - opcode constants `OPC_LI`, `OPC_J`, `OPC_JZ`, `OPC_JNZ`, `OPC_HALT`, `OPC_ALU_BIT`;
  - state enum `uc_state_t`;
  - ALU operation encodings.
- One sub-module, `uc_decode`: purely combinational Opcode/z to strobes. `uc_seq` gates its outputs by state.

## Test plan
- Reset: drop `reset` mid-run → all outputs at reset values within the same cycle; BOOT lasts exactly one cycle after release; `icount=0`.
- Opcode `101000` in EXEC → `Op=010`, `we3=1`, `wez=1`, `s_inc=1`; `icount` increments by 1.
- JZ with `z=1` → `s_inc=0`; JZ with `z=0` → `s_inc=1`; JNZ gives the opposite result.
- HALT opcode → next cycle `halted=1`, `pc_en=0`, `icount` frozen; `start` pulse → EXEC the following cycle.
- Set `CNT_W=4` and execute 17 instructions → `icount` wraps to 1.
- With `UC_STEP_EN` in HALT, `step_req` pulse → exactly one EXEC cycle, then `step_ack` for one cycle, then HALT again. `start` and `step_req` together → EXEC with no ack.
